apb_wait_slave: RTL and testbench
=================================

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port id, input, 2 bits: this responder's select code; static after reset.
REQ-004 SHALL have port sel, input, 2 bits: APB select; the responder is addressed when sel == id.
REQ-005 SHALL have port enable, input, 1 bit: APB access-phase flag.
REQ-006 SHALL have port write, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 8 bits: byte address.
REQ-008 SHALL have port wdata, input, 8 bits: write data.
REQ-009 SHALL have port rdata, output, 8 bits: read data, valid only while ready = 1 on a read.
REQ-010 SHALL have port ready, output, 1 bit: transfer completes on the rising edge where it is 1.
REQ-011 SHALL have port error, output, 1 bit: slave error, valid only while ready = 1.

Function
REQ-012 SHALL contain 16 x 8-bit data registers at addr 0x00-0x0F and a wait-config register WCFG[2:0] at addr 0x10; WCFG read returns {5'b0, WCFG}.
REQ-013 SHALL implement FSM states IDLE and ACCESS, plus a 3-bit wait counter cnt.
REQ-014 IDLE: when sel == id and enable = 0 at an edge, SHALL latch addr, write and wdata, load cnt = WCFG, and go to ACCESS.
REQ-015 ACCESS with sel == id, enable = 1 and cnt != 0: SHALL decrement cnt and hold ready = 0.
REQ-016 ACCESS with sel == id, enable = 1 and cnt == 0: SHALL drive ready = 1 combinationally in that cycle, commit the write or present rdata, then go to IDLE at that edge.
REQ-017 Latency: with WCFG = N, ready SHALL rise in the (N+1)th enable cycle; N = 0 gives a zero-wait APB transfer.
REQ-018 Address > 0x10: SHALL complete with error = 1 and the normal wait count; writes are discarded and rdata = 0x00.
REQ-019 A write to 0x10 SHALL update WCFG from wdata[2:0] at the completing edge; the new value applies from the next transfer only.
REQ-020 rdata SHALL use the latched address, not the live addr.
REQ-021 Abort: if sel != id, or if enable = 0 while in ACCESS, the FSM SHALL return to IDLE with no register update and ready = 0.
REQ-022 Outside a completing ACCESS cycle, ready and error SHALL be 0 and rdata SHALL be 0x00.
REQ-023 A sel == id with enable = 1 while in IDLE (no setup phase) SHALL be ignored.
REQ-024 Back-to-back transfers SHALL be accepted: a setup phase in the cycle after completion is taken normally.

Reset
REQ-025 While reset = 1 at an edge: state = IDLE, cnt = 0, WCFG = 0, and all 16 data registers = 0x00.
REQ-026 While in reset, ready = 0, error = 0 and rdata = 0x00.
REQ-027 Reset asserted in ACCESS SHALL abandon the transfer with no register write.

Structure
REQ-028 A shared package apb_pkg SHALL hold the state enum (IDLE, ACCESS), REG_COUNT = 16, WCFG_ADDR = 8'h10, and the data/address widths (8).
REQ-029 The register file SHALL be a sub-module apb_regfile (16x8, synchronous write, combinational read); the FSM and counter stay in apb_wait_slave.

Verification
REQ-030 The bench SHALL cover:
- WCFG = 0, id = 1: write 0x05 to 0x03, then read 0x03 -> ready in the first enable cycle both times; rdata = 0x05; error = 0.
- Write 0x05 to 0x10, then write 0x04 to 0x05 -> ready after exactly 5 wait cycles (6th enable cycle); readback of 0x05 = 0x04, also with 5 waits.
- Read 0x20 with WCFG = 1 -> ready in the 2nd enable cycle, error = 1, rdata = 0x00; no register changes.
- sel = 2 while id = 1 (write 0xAA to 0x01) -> ready stays 0 throughout; register 0x01 unchanged.
- Abort: setup a write, drop sel during a wait cycle -> FSM returns to IDLE, no write; the next full transfer completes normally.
- Assert reset during a wait cycle of a write to 0x02 -> after reset, WCFG = 0 and read 0x02 returns 0x00 with zero waits.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB wait-state responder.
// Holds the FSM state enum, register-file size, WCFG address and bus widths.
package apb_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 8;
   localparam int REG_COUNT = 16;
   localparam int IDX_W     = $clog2(REG_COUNT);

   localparam logic [ADDR_W-1:0] WCFG_ADDR = 8'h10;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between a requester and the wait-state responder.
// Signals: sel, enable, write, addr, wdata (to responder); rdata, ready, error (back).
interface apb_wait_slave_if;
   import apb_pkg::*;

   logic [1:0]        sel;
   logic              enable;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              error;

   modport master (
      output sel, enable, write, addr, wdata,
      input  rdata, ready, error
   );

   modport slave (
      input  sel, enable, write, addr, wdata,
      output rdata, ready, error
   );

endinterface

// File: rtl/apb_regfile.sv
// 16 x 8-bit register file: synchronous write, combinational read.
// Ports: clk, reset (sync, active-high, clears all), we/waddr/wdata, raddr/rdata.
module apb_regfile
   import apb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [REG_COUNT];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_wait_slave.sv
// APB responder with programmable wait states (WCFG) in front of a 16x8 regfile.
// Ports: clk, reset (sync, active-high), id (select code), bus (APB slave modport).
module apb_wait_slave
   import apb_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             id,
   apb_wait_slave_if.slave        bus
);

   state_t            state_q;
   state_t            state_d;
   logic [2:0]        cnt_q;
   logic [2:0]        wcfg_q;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_write;
   logic [DATA_W-1:0] lat_wdata;

   logic              hit;
   logic              setup;
   logic              done;
   logic              in_rf;
   logic              is_wcfg;
   logic              rf_we;
   logic              wcfg_we;
   logic [DATA_W-1:0] rf_rdata;

   assign hit     = (bus.sel == id);
   assign setup   = (state_q == IDLE) && hit && !bus.enable;
   assign in_rf   = (lat_addr[ADDR_W-1:IDX_W] == '0);
   assign is_wcfg = (lat_addr == WCFG_ADDR);

   // Completion is gated by reset so nothing commits or shows while in reset.
   assign done = !reset && (state_q == ACCESS) && hit
               && bus.enable && (cnt_q == 3'd0);

   assign rf_we   = done && lat_write && in_rf;
   assign wcfg_we = done && lat_write && is_wcfg;

   apb_regfile u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (rf_we),
      .waddr (lat_addr[IDX_W-1:0]),
      .wdata (lat_wdata),
      .raddr (lat_addr[IDX_W-1:0]),
      .rdata (rf_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (hit && !bus.enable) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Leaves on completion, deselect or a dropped enable.
            if (!hit || !bus.enable || cnt_q == 3'd0) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      bus.ready = done;
      bus.error = done && !in_rf && !is_wcfg;
      bus.rdata = '0;
      if (done && !lat_write) begin
         if (in_rf) begin
            bus.rdata = rf_rdata;
         end else if (is_wcfg) begin
            bus.rdata = {5'b0, wcfg_q};
         end
      end
   end

   // WCFG is loaded into cnt at setup, so a WCFG write only
   // affects transfers that begin after it completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         wcfg_q    <= '0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_wdata <= '0;
      end else begin
         if (setup) begin
            lat_addr  <= bus.addr;
            lat_write <= bus.write;
            lat_wdata <= bus.wdata;
            cnt_q     <= wcfg_q;
         end else if (state_q == ACCESS && hit && bus.enable
                      && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (wcfg_we) begin
            wcfg_q <= lat_wdata[2:0];
         end
      end
   end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: directed transfers push expectations,
// a monitor pops and checks them whenever ready is seen.
module tb_apb_wait_slave;
   import apb_pkg::*;

   localparam logic [1:0] ID = 2'd1;

   typedef struct {
      string      name;
      int         waits;
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   logic clk;
   logic reset;
   logic [1:0] id;
   int total;
   int bad;
   int ecnt;
   exp_t q[$];

   apb_wait_slave_if bus ();

   apb_wait_slave dut (
      .clk   (clk),
      .reset (reset),
      .id    (id),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_quiet(input string name);
      total++;
      if (bus.ready !== 1'b0 || bus.error !== 1'b0 || bus.rdata !== 8'h00) begin
         bad++;
         $display("FAIL %s: ready=%b error=%b rdata=%h, want 0/0/00",
                  name, bus.ready, bus.error, bus.rdata);
      end
   endtask

   task automatic xfer(input string name, input logic w,
                       input logic [7:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] rd,
                       input logic err);
      exp_t e;
      bit got;
      e.name  = name;
      e.waits = waits;
      e.rdata = rd;
      e.err   = err;
      q.push_back(e);
      @(posedge clk); #1;
      bus.sel    = ID;
      bus.enable = 1'b0;
      bus.write  = w;
      bus.addr   = a;
      bus.wdata  = d;
      @(posedge clk); #1;
      bus.enable = 1'b1;
      // Live addr/wdata change after setup; only latched values may matter.
      bus.addr   = ~a;
      bus.wdata  = ~d;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            got = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s: ready never seen, want %0d waits", name, waits);
         void'(q.pop_back());
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bus.sel    = 2'd0;
      bus.enable = 1'b0;
      bus.write  = 1'b0;
   endtask

   initial begin
      exp_t e;
      ecnt = 0;
      forever begin
         @(negedge clk);
         if (bus.sel == ID && bus.enable) ecnt++;
         else ecnt = 0;
         if (bus.ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ready: ready=1 rdata=%h error=%b, want no ready",
                        bus.rdata, bus.error);
            end else begin
               e = q.pop_front();
               if (ecnt - 1 != e.waits || bus.rdata !== e.rdata
                   || bus.error !== e.err) begin
                  bad++;
                  $display("FAIL %s: waits=%0d rdata=%h error=%b, want waits=%0d rdata=%h error=%b",
                           e.name, ecnt - 1, bus.rdata, bus.error,
                           e.waits, e.rdata, e.err);
               end
            end
            ecnt = 0;
         end
      end
   end

   initial begin
      total      = 0;
      bad        = 0;
      id         = ID;
      reset      = 1'b1;
      bus.sel    = 2'd0;
      bus.enable = 1'b0;
      bus.write  = 1'b0;
      bus.addr   = 8'h00;
      bus.wdata  = 8'h00;
      @(negedge clk);
      check_quiet("reset_outputs");
      @(posedge clk); #1;
      reset = 1'b0;

      // Zero-wait transfers; back-to-back write then read.
      xfer("wr03_w0",  1'b1, 8'h03, 8'h05, 0, 8'h00, 1'b0);
      xfer("rd03_w0",  1'b0, 8'h03, 8'h00, 0, 8'h05, 1'b0);
      xfer("wcfg5",    1'b1, 8'h10, 8'h05, 0, 8'h00, 1'b0);
      xfer("wr05_w5",  1'b1, 8'h05, 8'h04, 5, 8'h00, 1'b0);
      xfer("rd05_w5",  1'b0, 8'h05, 8'h00, 5, 8'h04, 1'b0);
      xfer("rdwcfg5",  1'b0, 8'h10, 8'h00, 5, 8'h05, 1'b0);
      xfer("wcfg1",    1'b1, 8'h10, 8'hF9, 5, 8'h00, 1'b0);
      idle();

      // Out-of-range accesses with one wait state.
      xfer("rd20_err", 1'b0, 8'h20, 8'h00, 1, 8'h00, 1'b1);
      xfer("wr30_err", 1'b1, 8'h30, 8'h33, 1, 8'h00, 1'b1);
      xfer("rd03_keep",1'b0, 8'h03, 8'h00, 1, 8'h05, 1'b0);
      xfer("rdwcfg1",  1'b0, 8'h10, 8'h00, 1, 8'h01, 1'b0);
      idle();

      // Other responder selected: never ready, no write.
      @(posedge clk); #1;
      bus.sel    = 2'd2;
      bus.enable = 1'b0;
      bus.write  = 1'b1;
      bus.addr   = 8'h01;
      bus.wdata  = 8'hAA;
      @(negedge clk);
      check_quiet("sel2_setup");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.enable = 1'b1;
         @(negedge clk);
         check_quiet("sel2_access");
      end
      idle();
      xfer("rd01_clean", 1'b0, 8'h01, 8'h00, 1, 8'h00, 1'b0);
      xfer("wcfg3",      1'b1, 8'h10, 8'h03, 1, 8'h00, 1'b0);
      idle();

      // Abort mid-wait by dropping sel.
      @(posedge clk); #1;
      bus.sel    = ID;
      bus.enable = 1'b0;
      bus.write  = 1'b1;
      bus.addr   = 8'h06;
      bus.wdata  = 8'h77;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus.enable = 1'b1;
         @(negedge clk);
         check_quiet("abort_wait");
      end
      @(posedge clk); #1;
      bus.sel    = 2'd0;
      bus.enable = 1'b0;
      @(negedge clk);
      check_quiet("abort_drop");
      xfer("wr07_after", 1'b1, 8'h07, 8'h66, 3, 8'h00, 1'b0);
      xfer("rd06_nowr",  1'b0, 8'h06, 8'h00, 3, 8'h00, 1'b0);
      xfer("rd07",       1'b0, 8'h07, 8'h00, 3, 8'h66, 1'b0);
      idle();

      // Reset during a wait cycle of a write.
      @(posedge clk); #1;
      bus.sel    = ID;
      bus.enable = 1'b0;
      bus.write  = 1'b1;
      bus.addr   = 8'h02;
      bus.wdata  = 8'h99;
      @(posedge clk); #1;
      bus.enable = 1'b1;
      @(negedge clk);
      check_quiet("rst_wait");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_quiet("rst_active");
      @(posedge clk); #1;
      reset      = 1'b0;
      bus.sel    = 2'd0;
      bus.enable = 1'b0;
      xfer("rdwcfg_rst", 1'b0, 8'h10, 8'h00, 0, 8'h00, 1'b0);
      xfer("rd02_rst",   1'b0, 8'h02, 8'h00, 0, 8'h00, 1'b0);
      xfer("rd03_rst",   1'b0, 8'h03, 8'h00, 0, 8'h00, 1'b0);
      idle();

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL queue_drain: pending=%0d, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1);
   end

endmodule
